led_bar_decoder: RTL and testbench
==================================

// Module: led_bar_decoder
// PURPOSE
//  Receive-side checker for the 8-LED bar animation bus. Samples the bar
//  pattern and filters blink/glitch frames with a stability window. Decodes
//  thermometer code to a level 0..8 and tracks fill/empty direction.
//  Flags illegal patterns and illegal level steps, and counts completed fill
//  peaks. Sits on the LED output bus as a self-check/monitor block.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples needed to accept a frame (>=1)
//  CNT_W          16  width of cycle_cnt_o (wraps)
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-high
//  clear_i       in   1      sync clear of cycle_cnt_o, err_cnt_o
//  bar_in        in   8      LED bar pattern; bit0 = bottom LED
//  level_o       out  4      last accepted level 0..8
//  level_valid_o out  1      1-cycle pulse: new level accepted
//  dir_o         out  1      1 = filling, 0 = emptying
//  thermo_err_o  out  1      1-cycle pulse: stable non-thermometer pattern
//  seq_err_o     out  1      1-cycle pulse: illegal level step
//  err_cnt_o     out  8      saturating count of thermo+seq errors
//  cycle_cnt_o   out  CNT_W  completed peaks (level 7 -> 8)
// BEHAVIOUR
//  Reset: level_o=0, dir_o=1, all pulses 0, counters 0.
//  Reset: internal accepted pattern = 8'h00, last_nz = 0, candidate = 8'h00,
//    stab_cnt = 0.
//  Filter: bar_in is registered into bar_q at every edge.
//  Filter: bar_q != cand -> cand<=bar_q, stab_cnt<=1.
//  Filter: otherwise stab_cnt increments, saturating at STABLE_CYCLES.
//  Accept: fires on the edge where stab_cnt reaches STABLE_CYCLES, once per
//    stable run, and only if cand != accepted pattern.
//  Latency: outputs update STABLE_CYCLES+1 edges after bar_in first presents
//    the new value.
//  Glitch: a run shorter than STABLE_CYCLES produces no output activity.
//  Thermo check: legal patterns are 2^k-1, k=0..8, giving level N = k.
//  Illegal pattern: thermo_err_o pulses and err_cnt_o increments.
//    level_o, accepted pattern and dir_o are unchanged; no level_valid_o.
//  Legal pattern: accepted<=cand, level_o<=N, level_valid_o pulses.
//  N = 0 (blink-off/empty): no sequence check; last_nz and dir_o unchanged.
//  N > 0, dir_o=1: legal if N==last_nz or N==last_nz+1.
//  N > 0, dir_o=0: legal if N==last_nz or N==last_nz-1.
//    Also legal: last_nz==1 and N==2, which sets dir_o=1.
//  Illegal step: seq_err_o pulses in the same cycle as level_valid_o and
//    err_cnt_o increments. Resync: last_nz<=N; N==8 -> dir_o=0;
//    N==1 -> dir_o=1.
//  Legal N==8: dir_o<=0. If last_nz==7, cycle_cnt_o increments.
//  After any N>0: last_nz<=N.
//  err_cnt_o saturates at 8'hFF. cycle_cnt_o wraps mod 2^CNT_W.
//  Thermo and seq errors are never simultaneous; err_cnt_o adds at most 1
//    per cycle.
//  clear_i: wins over a same-cycle increment (counter ends at 0). Does not
//    touch level/dir state.
//  rst mid-frame: all state returns to reset values immediately, with no
//    partial pulse.
// TESTING
//  1. Reset, then 00,01,03,..,FF,7F,..,01,00, each held 6 cycles
//     (STABLE_CYCLES=4) -> level_o 0..8..0, 16 level_valid_o pulses,
//     dir_o falls on 8 and stays 0 down to 1; cycle_cnt_o=1, err_cnt_o=0.
//  2. Hold 03 stable; insert 3-cycle 07 glitch -> no level_valid_o;
//     level_o stays 2.
//  3. Stable 05 -> thermo_err_o 1 pulse at edge 5; err_cnt_o=1;
//     level_o unchanged.
//  4. From level 2 (filling), stable 0F -> level_o=4, seq_err_o with
//     level_valid_o, err_cnt_o+1, dir_o stays 1.
//  5. Level 3 blink: 07,00,07 each 6 cycles -> levels 3,0,3;
//     no seq_err_o; dir_o unchanged.
//  6. Drive err_cnt_o to FF, then one more error -> stays FF.
//     Assert clear_i on the same cycle as an error -> 0.
//     Assert rst mid-run -> all outputs are reset values on the next sample.

Source files
------------

// File: rtl/led_bar_decoder.sv
// LED bar bus monitor: debounces the 8-LED pattern, decodes the thermometer level,
// tracks fill/empty direction and flags illegal patterns and illegal level steps.
module led_bar_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [7:0]       bar_in,
  output logic [3:0]       level_o,
  output logic             level_valid_o,
  output logic             dir_o,
  output logic             thermo_err_o,
  output logic             seq_err_o,
  output logic [7:0]       err_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

  logic [7:0]       bar_q, cand_q, cand_d, acc_q, acc_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic [3:0]       level_q, level_d, last_q, last_d, n_lvl;
  logic             dir_q, dir_d, vld_q, vld_d, terr_q, terr_d, serr_q, serr_d;
  logic [7:0]       err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             fire, step_ok, err_inc, cyc_inc;

  // Legal bar patterns are contiguous ones from the bottom LED: p & (p+1) == 0.
  function automatic logic is_thermo(input logic [7:0] p);
    logic [8:0] p1;
    p1 = {1'b0, p} + 9'd1;
    return (p & p1[7:0]) == 8'h00;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] p);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, p[i]};
    return c;
  endfunction

  always_comb begin
    cand_d  = cand_q;
    stab_d  = stab_q;
    if (bar_q != cand_q) begin
      cand_d = bar_q;
      stab_d = SW'(1);
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + SW'(1);
    end
    // Second term covers STABLE_CYCLES==1, where a new run starts already saturated.
    fire    = (stab_d == STAB_MAX) && ((bar_q != cand_q) || (stab_q != STAB_MAX));
    n_lvl   = popcnt(cand_d);
    acc_d   = acc_q;
    level_d = level_q;
    last_d  = last_q;
    dir_d   = dir_q;
    vld_d   = 1'b0;
    terr_d  = 1'b0;
    serr_d  = 1'b0;
    err_inc = 1'b0;
    cyc_inc = 1'b0;
    step_ok = 1'b1;
    if (fire && (cand_d != acc_q)) begin
      if (!is_thermo(cand_d)) begin
        terr_d  = 1'b1;
        err_inc = 1'b1;
      end else begin
        acc_d   = cand_d;
        level_d = n_lvl;
        vld_d   = 1'b1;
        if (n_lvl != 4'd0) begin
          if (dir_q)
            step_ok = (n_lvl == last_q) || (n_lvl == last_q + 4'd1);
          else
            step_ok = (n_lvl == last_q) || (n_lvl == last_q - 4'd1) ||
                      ((last_q == 4'd1) && (n_lvl == 4'd2));
          last_d = n_lvl;
          if (step_ok) begin
            if (!dir_q && (last_q == 4'd1) && (n_lvl == 4'd2)) dir_d = 1'b1;
            if (n_lvl == 4'd8) begin
              dir_d   = 1'b0;
              cyc_inc = (last_q == 4'd7);
            end
          end else begin
            serr_d  = 1'b1;
            err_inc = 1'b1;
            if (n_lvl == 4'd8)      dir_d = 1'b0;
            else if (n_lvl == 4'd1) dir_d = 1'b1;
          end
        end
      end
    end
    if (clear_i)                        err_d = 8'h00;
    else if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
    else                                err_d = err_q;
    cyc_d = clear_i ? '0 : cyc_q + CNT_W'(cyc_inc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_q   <= 8'h00;
      cand_q  <= 8'h00;
      stab_q  <= '0;
      acc_q   <= 8'h00;
      level_q <= 4'd0;
      last_q  <= 4'd0;
      dir_q   <= 1'b1;
      vld_q   <= 1'b0;
      terr_q  <= 1'b0;
      serr_q  <= 1'b0;
      err_q   <= 8'h00;
      cyc_q   <= '0;
    end else begin
      bar_q   <= bar_in;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      acc_q   <= acc_d;
      level_q <= level_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      vld_q   <= vld_d;
      terr_q  <= terr_d;
      serr_q  <= serr_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  assign level_o       = level_q;
  assign level_valid_o = vld_q;
  assign dir_o         = dir_q;
  assign thermo_err_o  = terr_q;
  assign seq_err_o     = serr_q;
  assign err_cnt_o     = err_q;
  assign cycle_cnt_o   = cyc_q;

endmodule

// File: tb/tb_led_bar_decoder.sv
// Directed bench for led_bar_decoder: sweep, glitch, thermo/seq errors, blink,
// counter saturation, clear priority and asynchronous reset.
module tb_led_bar_decoder;
  logic        clk = 1'b0;
  logic        rst, clear_i;
  logic [7:0]  bar_in;
  logic [3:0]  level_o;
  logic        level_valid_o, dir_o, thermo_err_o, seq_err_o;
  logic [7:0]  err_cnt_o;
  logic [15:0] cycle_cnt_o;

  int checks = 0;
  int failures = 0;
  int n_vld = 0, n_terr = 0, n_serr = 0;

  led_bar_decoder #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .bar_in(bar_in),
    .level_o(level_o), .level_valid_o(level_valid_o), .dir_o(dir_o),
    .thermo_err_o(thermo_err_o), .seq_err_o(seq_err_o),
    .err_cnt_o(err_cnt_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  // Pulse counters sample the pre-edge value, so each 1-cycle pulse counts once.
  always @(posedge clk) begin
    if (level_valid_o) n_vld  <= n_vld + 1;
    if (thermo_err_o)  n_terr <= n_terr + 1;
    if (seq_err_o)     n_serr <= n_serr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] p, input int n);
    bar_in = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic zero_pulses();
    n_vld = 0; n_terr = 0; n_serr = 0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; clear_i = 1'b0; bar_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_level", level_o, 0);
    chk("rst_dir", dir_o, 1);
    chk("rst_vld", level_valid_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_cyc", cycle_cnt_o, 0);
    rst = 1'b0;
    zero_pulses();

    // Sweep up and down
    step(8'h00, 6);
    bar_in = 8'h01;
    repeat (4) @(negedge clk);
    chk("lat_early_vld", level_valid_o, 0);
    @(negedge clk);
    chk("lat_vld", level_valid_o, 1);
    chk("lat_level", level_o, 1);
    @(negedge clk);
    for (int k = 2; k <= 8; k++) begin
      pat = 8'((16'h1 << k) - 1);
      step(pat, 6);
      chk("up_level", level_o, k);
    end
    chk("peak_dir", dir_o, 0);
    chk("peak_cyc", cycle_cnt_o, 1);
    for (int k = 7; k >= 1; k--) begin
      pat = 8'((16'h1 << k) - 1);
      step(pat, 6);
      chk("down_level", level_o, k);
      chk("down_dir", dir_o, 0);
    end
    step(8'h00, 6);
    chk("sweep_end_level", level_o, 0);
    chk("sweep_vld_count", n_vld, 16);
    chk("sweep_err", err_cnt_o, 0);
    chk("sweep_serr", n_serr, 0);
    chk("sweep_cyc", cycle_cnt_o, 1);

    // Level 2 via the 1->2 turnaround, then a short glitch
    step(8'h03, 6);
    chk("t2_level", level_o, 2);
    chk("t2_dir", dir_o, 1);
    chk("t2_serr", n_serr, 0);
    zero_pulses();
    step(8'h07, 3);
    step(8'h03, 8);
    chk("glitch_vld", n_vld, 0);
    chk("glitch_level", level_o, 2);

    // Non-thermometer pattern
    bar_in = 8'h05;
    repeat (4) @(negedge clk);
    chk("thermo_early", thermo_err_o, 0);
    @(negedge clk);
    chk("thermo_pulse", thermo_err_o, 1);
    chk("thermo_err_cnt", err_cnt_o, 1);
    chk("thermo_level", level_o, 2);
    @(negedge clk);
    chk("thermo_vld_count", n_vld, 0);
    step(8'h03, 6);
    chk("thermo_back_vld", n_vld, 0);

    // Skip step 2 -> 4 while filling
    bar_in = 8'h0F;
    repeat (5) @(negedge clk);
    chk("skip_vld", level_valid_o, 1);
    chk("skip_serr", seq_err_o, 1);
    chk("skip_level", level_o, 4);
    chk("skip_err_cnt", err_cnt_o, 2);
    chk("skip_dir", dir_o, 1);
    @(negedge clk);

    // 4 -> 3 while filling is a seq error; then blink at level 3
    step(8'h07, 6);
    chk("resync_err_cnt", err_cnt_o, 3);
    zero_pulses();
    step(8'h00, 6);
    chk("blink_off_level", level_o, 0);
    step(8'h07, 6);
    chk("blink_on_level", level_o, 3);
    chk("blink_serr", n_serr, 0);
    chk("blink_vld", n_vld, 2);
    chk("blink_dir", dir_o, 1);
    chk("blink_err_cnt", err_cnt_o, 3);

    // Saturate the error counter with alternating illegal patterns
    for (int i = 0; i < 260; i++) step((i % 2 == 0) ? 8'h05 : 8'h09, 6);
    chk("err_sat", err_cnt_o, 8'hFF);
    step(8'h0B, 6);
    chk("err_sat_hold", err_cnt_o, 8'hFF);

    // clear_i on the same edge as an error
    bar_in = 8'h05;
    repeat (4) @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    chk("clear_terr", thermo_err_o, 1);
    chk("clear_err_cnt", err_cnt_o, 0);
    chk("clear_cyc", cycle_cnt_o, 0);
    chk("clear_level", level_o, 3);
    @(negedge clk);

    // Asynchronous reset during a pulse (1 after level 3 filling is a seq error)
    bar_in = 8'h01;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_vld", level_valid_o, 1);
    chk("pre_rst_serr", seq_err_o, 1);
    rst = 1'b1;
    #1;
    chk("arst_vld", level_valid_o, 0);
    chk("arst_serr", seq_err_o, 0);
    chk("arst_level", level_o, 0);
    chk("arst_dir", dir_o, 1);
    chk("arst_err", err_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
    step(8'h00, 6);
    chk("post_rst_level", level_o, 0);
    chk("post_rst_vld", level_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
